capp_array: RTL and testbench
=============================

# capp_array

Parametrised content-addressable parallel processor array. It holds DEPTH words of WIDTH bits and a per-word tag bit, and executes associative commands (search, masked write, select-first, read, count) issued over a valid/ready command port. It replaces the separate fixed-size compare/cells/tags trio, adding configurable geometry, a lane-sliced multi-cycle sweep, conjunctive search and a registered response channel.

## Interface
- WIDTH, 32, word width in bits
- DEPTH, 64, number of cells; must be a multiple of LANES (elaboration error otherwise)
- LANES, 16, cells processed per clock during sweeps; S = DEPTH/LANES sweep cycles
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on edge where cmd_valid && cmd_ready
- cmd_op  in  3  opcode (see Operation)
- cmd_data  in  WIDTH  comparand / write data / cell index
- cmd_mask  in  WIDTH  bit-enable mask for SEARCH and WRITE
- rsp_valid  out  1  one-cycle completion pulse, exactly one per accepted command
- rsp_hit  out  1  OR of all tags after the command
- rsp_data  out  WIDTH  READ result, else 0
- rsp_count  out  clog2(DEPTH)+1  COUNT result, else 0
- tags  out  DEPTH  live tag register

## Operation
- 000 SET_ALL: all tags = 1. Single-cycle.
- 001 CLEAR_ALL: all tags = 0. Single-cycle.
- 010 SEARCH: tag[i] <= tag[i] & (((cell[i] ^ cmd_data) & cmd_mask) == 0). Conjunctive; only tagged cells can remain tagged. Sweep.
- 011 SELECT_FIRST: keep only the lowest-index set tag; no-op when no tag is set. Single-cycle.
- 100 WRITE: for each tagged cell, bits where cmd_mask=1 take cmd_data; other bits unchanged. Sweep.
- 101 READ: rsp_data = cell of lowest-index tagged cell; 0 if none. Single-cycle.
- 110 COUNT: rsp_count = number of set tags, accumulated per lane group. Sweep.
- 111 SET_INDEX: tags = one-hot at cmd_data mod DEPTH. Single-cycle.
- cmd_data/cmd_mask/cmd_op are captured at acceptance; later input changes have no effect.
- FSM: IDLE -> (single-cycle op) RESP; IDLE -> (sweep op) SWEEP(g=0..S-1) -> RESP; RESP -> IDLE.
- Sweep: group g covers cells g*LANES .. g*LANES+LANES-1. The tags output shows partial progress.
- mask = 0: SEARCH leaves tags unchanged; WRITE changes nothing.

## Timing
- Reset (async assert, sync-safe release): all cells 0, tags 0, state IDLE, rsp_valid 0, rsp_hit 0, rsp_data 0, rsp_count 0, cmd_ready 1.
- cmd_ready = IDLE && !rsp_valid.
- Latency from acceptance edge E: single-cycle ops update state and set rsp_valid at E+1. Sweep ops process group g at E+1+g; rsp_valid is set at E+S together with the last group.
- rsp_valid clears on the next edge; cmd_ready rises on the same edge. Throughput is one command per latency+1 cycles.
- rsp_hit, rsp_data and rsp_count are valid only while rsp_valid=1; they hold until the next response.
- cmd_valid while cmd_ready=0 is ignored; there is no queueing.
- RST_N asserted mid-sweep aborts immediately; the full reset state applies and no rsp_valid is produced.

## Test plan
Parameters: WIDTH=32, DEPTH=64, LANES=16 (S=4).
- Reset: RST_N low then high -> tags=0, cmd_ready=1, rsp_valid=0. SET_ALL; COUNT -> rsp_count=64, rsp_valid exactly 4 edges after acceptance.
- Load and exact search: for i=0..63, SET_INDEX i then WRITE data=3*i mask=0xFFFFFFFF. Then SET_ALL; SEARCH 90 all-ones -> tags=1<<30, rsp_hit=1; COUNT -> 1; READ -> rsp_data=90.
- Masked search and select: SET_ALL; SEARCH data=0 mask=1 -> even i tagged, COUNT=32; SELECT_FIRST -> tags=1; READ -> rsp_data=0, rsp_hit=1.
- Masked write: SET_INDEX 2; WRITE data=0xFFFF0000 mask=0xFFFF0000; READ -> 0xFFFF0006. Cell 3 is unchanged (reads 9).
- Empty set: CLEAR_ALL; SEARCH 90 -> rsp_hit=0; READ -> rsp_data=0, rsp_hit=0; COUNT -> 0; SELECT_FIRST -> tags=0.
- Handshake and reset: cmd_valid held high during a WRITE sweep -> only one command accepted and one rsp_valid pulse. RST_N low at E+2 of a WRITE -> no rsp_valid; after release, COUNT=0 and READ after SET_ALL returns 0.

Source files
------------

// File: rtl/capp_array.sv
// capp_array: associative processor array; search/write/select/read/count over DEPTH tagged words.
// Latency: single-cycle ops respond 1 cycle after acceptance; sweep ops respond DEPTH/LANES cycles after.
// Backpressure: cmd_ready is low from acceptance through the response cycle; commands are never queued.
module capp_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int LANES = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [WIDTH-1:0]         cmd_mask,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(DEPTH):0]   rsp_count,
  output logic [DEPTH-1:0]         tags
);

  localparam int S  = DEPTH / LANES;
  localparam int GW = (S > 1) ? $clog2(S) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // A partial lane group would leave cells outside every sweep.
  generate
    if ((DEPTH % LANES) != 0) begin : g_geom_check
      $error("capp_array: DEPTH must be a multiple of LANES");
    end
  endgenerate

  localparam logic [2:0] OP_SET_ALL   = 3'd0;
  localparam logic [2:0] OP_CLEAR_ALL = 3'd1;
  localparam logic [2:0] OP_SEARCH    = 3'd2;
  localparam logic [2:0] OP_SEL_FIRST = 3'd3;
  localparam logic [2:0] OP_WRITE     = 3'd4;
  localparam logic [2:0] OP_READ      = 3'd5;
  localparam logic [2:0] OP_COUNT     = 3'd6;
  localparam logic [2:0] OP_SET_INDEX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SINGLE,
    ST_SWEEP,
    ST_RESP
  } state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic [2:0]                    op_q;
  logic [WIDTH-1:0]              data_q;
  logic [WIDTH-1:0]              mask_q;
  logic [GW-1:0]                 grp;
  logic [CW-1:0]                 count_acc;
  logic [CW-1:0]                 count_nxt;
  logic [DEPTH-1:0]              tags_nxt;
  logic [DEPTH-1:0][WIDTH-1:0]   cells;
  logic                          first_found;
  logic [IW-1:0]                 first_idx;
  logic [IW-1:0]                 set_idx;
  logic [IW-1:0]                 idx;
  logic                          last_grp;
  logic                          rsp_set;
  logic                          accept;
  logic                          cmd_is_sweep;

  assign cmd_ready    = (state == ST_IDLE) && !rsp_valid;
  assign accept       = cmd_valid && cmd_ready;
  assign cmd_is_sweep = (cmd_op == OP_SEARCH) || (cmd_op == OP_WRITE) || (cmd_op == OP_COUNT);
  assign last_grp     = (grp == GW'(S - 1));
  assign set_idx      = IW'(data_q % DEPTH);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; rsp_set marks the edge that completes the command.
  always_comb begin
    state_nxt = state;
    rsp_set   = 1'b0;
    case (state)
      ST_IDLE:   if (accept) state_nxt = cmd_is_sweep ? ST_SWEEP : ST_SINGLE;
      ST_SINGLE: begin
        state_nxt = ST_RESP;
        rsp_set   = 1'b1;
      end
      ST_SWEEP:  if (last_grp) begin
        state_nxt = ST_RESP;
        rsp_set   = 1'b1;
      end
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Lowest-index set tag; descending scan so the smallest index wins.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tags[IW'(i)]) begin
        first_found = 1'b1;
        first_idx   = IW'(i);
      end
    end
  end

  // Next tag vector and running count for the current command step.
  always_comb begin
    tags_nxt  = tags;
    count_nxt = count_acc;
    idx       = '0;
    case (state)
      ST_SINGLE: begin
        case (op_q)
          OP_SET_ALL:   tags_nxt = '1;
          OP_CLEAR_ALL: tags_nxt = '0;
          OP_SEL_FIRST: begin
            tags_nxt = '0;
            if (first_found) tags_nxt[first_idx] = 1'b1;
          end
          OP_SET_INDEX: begin
            tags_nxt          = '0;
            tags_nxt[set_idx] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_SWEEP: begin
        for (int l = 0; l < LANES; l++) begin
          idx = IW'(int'(grp) * LANES + l);
          if (op_q == OP_SEARCH && (((cells[idx] ^ data_q) & mask_q) != '0))
            tags_nxt[idx] = 1'b0;
          if (op_q == OP_COUNT)
            count_nxt = count_nxt + CW'(tags[idx]);
        end
      end
      default: ;
    endcase
  end

  // Command capture, cell/tag updates and the registered response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q      <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      grp       <= '0;
      count_acc <= '0;
      tags      <= '0;
      cells     <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_data  <= '0;
      rsp_count <= '0;
    end else begin
      tags      <= tags_nxt;
      rsp_valid <= rsp_set;
      if (accept) begin
        op_q      <= cmd_op;
        data_q    <= cmd_data;
        mask_q    <= cmd_mask;
        grp       <= '0;
        count_acc <= '0;
      end
      if (state == ST_SWEEP) begin
        grp       <= grp + GW'(1);
        count_acc <= count_nxt;
        if (op_q == OP_WRITE) begin
          for (int l = 0; l < LANES; l++) begin
            if (tags[IW'(int'(grp) * LANES + l)])
              cells[IW'(int'(grp) * LANES + l)] <=
                (cells[IW'(int'(grp) * LANES + l)] & ~mask_q) | (data_q & mask_q);
          end
        end
      end
      if (rsp_set) begin
        rsp_hit   <= |tags_nxt;
        rsp_data  <= (op_q == OP_READ && first_found) ? cells[first_idx] : '0;
        rsp_count <= (op_q == OP_COUNT) ? count_nxt : '0;
      end
    end
  end

endmodule

// File: tb/tb_capp_array.sv
// tb_capp_array: directed and randomized commands against an array-level reference model.
// Latency: each command is checked for response latency (1 or DEPTH/LANES cycles).
// Backpressure: commands are issued only while cmd_ready is high; waits are cycle-bounded.
module tb_capp_array;
  localparam int W  = 32;
  localparam int D  = 64;
  localparam int L  = 16;
  localparam int CW = 7;

  localparam logic [2:0] SET_ALL = 3'd0, CLEAR_ALL = 3'd1, SEARCH = 3'd2, SEL_FIRST = 3'd3;
  localparam logic [2:0] WRITE = 3'd4, READ = 3'd5, COUNT = 3'd6, SET_INDEX = 3'd7;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [W-1:0]  cmd_mask;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [W-1:0]  rsp_data;
  logic [CW-1:0] rsp_count;
  logic [D-1:0]  tags;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mcells [D];
  logic [D-1:0] mtags;

  always #5 CLK = ~CLK;

  capp_array #(.WIDTH(W), .DEPTH(D), .LANES(L)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
    .rsp_count(rsp_count), .tags(tags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic int first_tag();
    for (int i = 0; i < D; i++) if (mtags[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) mcells[i] = '0;
    mtags = '0;
  endtask

  // Whole-array effect of one command, straight from the opcode table.
  task automatic model_apply(input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] m,
                             output logic hit, output logic [W-1:0] rd, output logic [CW-1:0] rc);
    int f;
    rd = '0;
    rc = '0;
    f  = first_tag();
    case (op)
      SET_ALL:   mtags = '1;
      CLEAR_ALL: mtags = '0;
      SEARCH:    for (int i = 0; i < D; i++) if (((mcells[i] ^ d) & m) != 0) mtags[i] = 1'b0;
      SEL_FIRST: begin mtags = '0; if (f >= 0) mtags[f] = 1'b1; end
      WRITE:     for (int i = 0; i < D; i++) if (mtags[i]) mcells[i] = (mcells[i] & ~m) | (d & m);
      READ:      if (f >= 0) rd = mcells[f];
      COUNT:     rc = CW'($countones(mtags));
      default:   begin mtags = '0; mtags[d % D] = 1'b1; end
    endcase
    hit = |mtags;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] m);
    int k;
    logic eh;
    logic [W-1:0] ed;
    logic [CW-1:0] ec;
    @(negedge CLK);
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge CLK); k++; end
    check("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_mask = m;
    @(posedge CLK); #1;
    // Scramble inputs after acceptance: only the captured values may matter.
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = $urandom; cmd_mask = $urandom;
    model_apply(op, d, m, eh, ed, ec);
    k = 0;
    do begin @(posedge CLK); #1; k++; end while (!rsp_valid && k < 20);
    check($sformatf("latency op%0d", op), k, (op == SEARCH || op == WRITE || op == COUNT) ? 4 : 1);
    check($sformatf("rsp_hit op%0d", op), rsp_hit, eh);
    check($sformatf("rsp_data op%0d", op), rsp_data, ed);
    check($sformatf("rsp_count op%0d", op), rsp_count, ec);
    check($sformatf("tags op%0d", op), tags, mtags);
    @(posedge CLK); #1;
    check("rsp_valid_pulse", rsp_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    int acc;
    int pulses;
    logic [W-1:0] rd;
    logic [W-1:0] rm;
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_mask = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_tags", tags, 0);
    check("reset_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    @(negedge CLK); RST_N = 1'b1;
    do_cmd(SET_ALL, 0, 0);
    do_cmd(COUNT, 0, 0);
    check("count_all_64", rsp_count, 64);

    // Load cell i with 3*i, then exact search
    for (int i = 0; i < D; i++) begin
      do_cmd(SET_INDEX, W'(i), 0);
      do_cmd(WRITE, W'(3 * i), '1);
    end
    do_cmd(SET_ALL, 0, 0);
    do_cmd(SEARCH, 90, '1);
    check("search90_tags", tags, 64'h1 << 30);
    check("search90_hit", rsp_hit, 1);
    do_cmd(COUNT, 0, 0);
    check("search90_count", rsp_count, 1);
    do_cmd(READ, 0, 0);
    check("search90_read", rsp_data, 90);

    // Masked search and select-first
    do_cmd(SET_ALL, 0, 0);
    do_cmd(SEARCH, 0, 1);
    check("even_tags", tags, 64'h5555_5555_5555_5555);
    do_cmd(COUNT, 0, 0);
    check("even_count", rsp_count, 32);
    do_cmd(SEL_FIRST, 0, 0);
    check("selfirst_tags", tags, 1);
    do_cmd(READ, 0, 0);
    check("selfirst_read", rsp_data, 0);
    check("selfirst_hit", rsp_hit, 1);

    // Masked write
    do_cmd(SET_INDEX, 2, 0);
    do_cmd(WRITE, 32'hFFFF_0000, 32'hFFFF_0000);
    do_cmd(READ, 0, 0);
    check("masked_write_read", rsp_data, 32'hFFFF_0006);
    do_cmd(SET_INDEX, 3 + 64, 0);
    do_cmd(READ, 0, 0);
    check("cell3_unchanged", rsp_data, 9);

    // Empty set and zero-mask corners
    do_cmd(CLEAR_ALL, 0, 0);
    do_cmd(SEARCH, 90, '1);
    check("empty_search_hit", rsp_hit, 0);
    do_cmd(READ, 0, 0);
    check("empty_read", rsp_data, 0);
    do_cmd(COUNT, 0, 0);
    check("empty_count", rsp_count, 0);
    do_cmd(SEL_FIRST, 0, 0);
    check("empty_selfirst", tags, 0);
    do_cmd(SET_ALL, 0, 0);
    do_cmd(SEARCH, 32'h1234_5678, 0);
    check("mask0_search", tags, '1);
    do_cmd(WRITE, 32'hDEAD_BEEF, 0);

    // Randomized commands
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0:       rm = '1;
        1:       rm = 32'h1 << $urandom_range(0, 31);
        2:       rm = 0;
        default: rm = $urandom;
      endcase
      rd = ($urandom_range(0, 1) == 1) ? mcells[$urandom_range(0, D - 1)] : W'($urandom);
      do_cmd(3'($urandom_range(0, 7)), rd, rm);
    end

    // cmd_valid held through a WRITE sweep: one acceptance, one response
    @(negedge CLK);
    check("hold_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = WRITE; cmd_data = 32'hA5A5_0F0F; cmd_mask = 32'h00FF_FF00;
    acc = 0; pulses = 0;
    repeat (5) begin
      if (cmd_ready) acc++;
      @(posedge CLK); #1;
      if (rsp_valid) pulses++;
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    @(posedge CLK); #1;
    if (rsp_valid) pulses++;
    check("hold_accepts", acc, 1);
    check("hold_pulses", pulses, 1);
    model_apply(WRITE, 32'hA5A5_0F0F, 32'h00FF_FF00, rd[0], rd, rm[CW-1:0]);
    do_cmd(READ, 0, 0);

    // Reset two edges into a WRITE sweep
    do_cmd(SET_ALL, 0, 0);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = WRITE; cmd_data = 32'h7777_7777; cmd_mask = '1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    check("midreset_tags", tags, 0);
    pulses = 0;
    repeat (3) begin @(posedge CLK); #1; if (rsp_valid) pulses++; end
    @(negedge CLK); RST_N = 1'b1;
    repeat (5) begin @(posedge CLK); #1; if (rsp_valid) pulses++; end
    check("midreset_no_rsp", pulses, 0);
    model_reset();
    do_cmd(COUNT, 0, 0);
    check("midreset_count", rsp_count, 0);
    do_cmd(SET_ALL, 0, 0);
    do_cmd(READ, 0, 0);
    check("midreset_read", rsp_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
